// File: rtl/accum_frame_packer_if.sv
// accum_frame_packer_if: FIFO-drain and UART-byte handshake bundle for accum_frame_packer.
interface accum_frame_packer_if;
  logic        data_ready_to_read;
  logic [15:0] data_in;
  logic        data_read;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_active;
  logic        frame_done;
  modport master (
    input  data_ready_to_read, data_in, tx_ready,
    output data_read, tx_data, tx_valid, frame_active, frame_done
  );
  modport slave (
    output data_ready_to_read, data_in, tx_ready,
    input  data_read, tx_data, tx_valid, frame_active, frame_done
  );
endinterface

// File: rtl/accum_frame_packer.sv
// accum_frame_packer: drains 16-bit FIFO samples into A5/count/MSB/LSB byte frames for the UART tx.
// Define ACCUM_PACKER_CHECKSUM_EN to append a two's-complement checksum byte to every frame.
module accum_frame_packer #(
  parameter int         SAMPLES_PER_FRAME = 125,
  parameter logic [7:0] HEADER_BYTE       = 8'hA5
) (
  input logic clk,
  input logic rst,
  accum_frame_packer_if.master bus
);
`ifdef ACCUM_PACKER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, CNT, LOAD, SEND_HI, SEND_LO, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, CNT, LOAD, SEND_HI, SEND_LO, DONE} state_t;
`endif
  localparam logic [7:0] N = 8'(SAMPLES_PER_FRAME);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       data_read_q, data_read_d;
  logic       frame_active_q, frame_active_d;
  logic       frame_done_q, frame_done_d;
  logic       xfer;
  assign xfer = tx_valid_q & bus.tx_ready;
`ifdef ACCUM_PACKER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, sum_acc;
  assign sum_acc = sum_q + tx_data_q;
  // every accepted byte before the checksum itself feeds the running sum
  always_comb
    sum_d = (state_q == DONE) ? 8'h00 : (xfer && state_q != CSUM) ? sum_acc : sum_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q;
    data_read_d = 1'b0;
    frame_active_d = frame_active_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.data_ready_to_read) begin
        state_d = HDR;
        tx_data_d = HEADER_BYTE;
        tx_valid_d = 1'b1;
        frame_active_d = 1'b1;
      end
      HDR: if (xfer) begin
        state_d = CNT;
        tx_data_d = N;
      end
      CNT: if (xfer) begin
        state_d = LOAD;
        tx_valid_d = 1'b0;
      end
      LOAD: if (bus.data_ready_to_read) begin
        state_d = SEND_HI;
        hold_d = bus.data_in[7:0];
        data_read_d = 1'b1;
        tx_data_d = bus.data_in[15:8];
        tx_valid_d = 1'b1;
      end
      SEND_HI: if (xfer) begin
        state_d = SEND_LO;
        tx_data_d = hold_q;
      end
      SEND_LO: if (xfer) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d != N) begin
          state_d = LOAD;
          tx_valid_d = 1'b0;
        end else begin
`ifdef ACCUM_PACKER_CHECKSUM_EN
          state_d = CSUM;
          tx_data_d = 8'h00 - sum_acc;
`else
          state_d = DONE;
          tx_valid_d = 1'b0;
          frame_done_d = 1'b1;
`endif
        end
      end
`ifdef ACCUM_PACKER_CHECKSUM_EN
      CSUM: if (xfer) begin
        state_d = DONE;
        tx_valid_d = 1'b0;
        frame_done_d = 1'b1;
      end
`endif
      DONE: begin
        state_d = IDLE;
        frame_active_d = 1'b0;
        cnt_d = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      hold_q <= 8'd0;
      tx_data_q <= 8'h00;
      tx_valid_q <= 1'b0;
      data_read_q <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef ACCUM_PACKER_CHECKSUM_EN
      sum_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      data_read_q <= data_read_d;
      frame_active_q <= frame_active_d;
      frame_done_q <= frame_done_d;
`ifdef ACCUM_PACKER_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
  assign bus.data_read = data_read_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.frame_active = frame_active_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_accum_frame_packer.sv
// tb_accum_frame_packer: directed frame vectors plus stall, underrun, reset-abort and long-frame sequences.
// Instance a runs N=2 frames, instance b runs the default N=125.
module tb_accum_frame_packer;
`ifdef ACCUM_PACKER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int LA = 6 + CS;
  localparam int LB = 252 + CS;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;
  accum_frame_packer_if ifa ();
  accum_frame_packer_if ifb ();
  accum_frame_packer #(.SAMPLES_PER_FRAME(2)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  accum_frame_packer dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
  logic [15:0] fmem_a [512];
  logic [15:0] fmem_b [512];
  int head_a = 0, tail_a = 0, head_b = 0, tail_b = 0;
  assign ifa.data_ready_to_read = (head_a != tail_a);
  assign ifa.data_in = fmem_a[head_a[8:0]];
  assign ifb.data_ready_to_read = (head_b != tail_b);
  assign ifb.data_in = fmem_b[head_b[8:0]];
  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  int pop_cyc_b [$];
  int pops_a = 0, pops_b = 0, dones_a = 0, dones_b = 0, cyc = 0;
  logic rdy_a = 1'b1, rdy_b = 1'b1, rnd_a = 1'b0, rnd_b = 1'b0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic        rnd;
    logic [55:0] exp;
  } vec_t;
  vec_t vt [4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // one clock of FIFO/UART environment; the transfer decision uses the ready value held across the next edge
  task automatic step();
    @(negedge clk);
    cyc++;
    ifa.tx_ready = rnd_a ? 1'($urandom_range(0, 1)) : rdy_a;
    ifb.tx_ready = rnd_b ? 1'($urandom_range(0, 1)) : rdy_b;
    if (ifa.tx_valid && ifa.tx_ready) cap_a.push_back(ifa.tx_data);
    if (ifb.tx_valid && ifb.tx_ready) cap_b.push_back(ifb.tx_data);
    if (ifa.data_read) begin pops_a++; head_a++; end
    if (ifb.data_read) begin pops_b++; head_b++; pop_cyc_b.push_back(cyc); end
    if (ifa.frame_done) dones_a++;
    if (ifb.frame_done) dones_b++;
    #1;
  endtask
  task automatic push_a(input logic [15:0] v);
    fmem_a[tail_a[8:0]] = v;
    tail_a++;
  endtask
  task automatic push_b(input logic [15:0] v);
    fmem_b[tail_b[8:0]] = v;
    tail_b++;
  endtask
  task automatic wait_done(input bit b, input int target, input string tag);
    int t = 0;
    while ((b ? dones_b : dones_a) < target && t < 5000) begin step(); t++; end
    chk({tag, " frame_done"}, b ? dones_b : dones_a, target);
  endtask
  // reference frame: header, count, MSB/LSB per sample, optional byte making the frame sum zero
  task automatic check_frame(input bit b, input string tag, input int n, input int cm, input int sb);
    logic [7:0] e, got, sum_e, sum_g;
    logic [15:0] s;
    int len, idx;
    len = 2 * n + 2 + CS;
    sum_e = 8'h00;
    sum_g = 8'h00;
    if ((b ? cap_b.size() : cap_a.size()) < cm + len) begin
      chk({tag, " bytes available"}, b ? cap_b.size() : cap_a.size(), cm + len);
      return;
    end
    for (int k = 0; k < len; k++) begin
      idx = sb + (k - 2) / 2;
      s = b ? fmem_b[idx[8:0]] : fmem_a[idx[8:0]];
      e = (k == 0) ? 8'hA5 : (k == 1) ? 8'(n) : (k >= 2 * n + 2) ? 8'h00 - sum_e :
          (k % 2 == 0) ? s[15:8] : s[7:0];
      got = b ? cap_b[cm + k] : cap_a[cm + k];
      sum_e += e;
      sum_g += got;
      chk($sformatf("%s byte %0d", tag, k), got, e);
    end
`ifdef ACCUM_PACKER_CHECKSUM_EN
    chk({tag, " frame sum"}, sum_g, 8'h00);
`endif
  endtask
  initial begin
    int cm, pm, dm, cyc_m, sb, bad, t;
    logic [55:0] ev;
    vt[0] = '{16'h1234, 16'hFF80, 1'b0, 56'hA5_02_12_34_FF_80_94};
    vt[1] = '{16'h0000, 16'h0000, 1'b1, 56'hA5_02_00_00_00_00_59};
    vt[2] = '{16'h8000, 16'h7FFF, 1'b1, 56'hA5_02_80_00_7F_FF_5B};
    vt[3] = '{16'h0102, 16'h0304, 1'b0, 56'hA5_02_01_02_03_04_4F};
    ifa.tx_ready = 1'b1;
    ifb.tx_ready = 1'b1;
    repeat (3) step();
    chk("reset tx_data", ifa.tx_data, 8'h00);
    chk("reset tx_valid", ifa.tx_valid, 1'b0);
    chk("reset data_read", ifa.data_read, 1'b0);
    chk("reset frame_active", ifa.frame_active, 1'b0);
    chk("reset frame_done", ifa.frame_done, 1'b0);
    chk("reset b tx_valid", ifb.tx_valid, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) step();
    chk("idle no frame", ifa.frame_active, 1'b0);
    // T1: table of two-sample frames
    for (int v = 0; v < 4; v++) begin
      rnd_a = vt[v].rnd;
      rdy_a = 1'b1;
      ev = vt[v].exp;
      cm = cap_a.size();
      pm = pops_a;
      dm = dones_a;
      push_a(vt[v].s0);
      push_a(vt[v].s1);
      wait_done(1'b0, dm + 1, $sformatf("T1 v%0d", v));
      rnd_a = 1'b0;
      repeat (3) step();
      chk($sformatf("T1 v%0d len", v), cap_a.size() - cm, LA);
      chk($sformatf("T1 v%0d pops", v), pops_a - pm, 2);
      chk($sformatf("T1 v%0d done once", v), dones_a - dm, 1);
      for (int k = 0; k < LA && cm + k < cap_a.size(); k++)
        chk($sformatf("T1 v%0d byte %0d", v, k), cap_a[cm + k], ev[55 - 8 * k -: 8]);
    end
    // T2: header stalled by txReady low
    rdy_a = 1'b0;
    step();
    cm = cap_a.size();
    sb = tail_a;
    push_a(16'hABCD);
    push_a(16'h0001);
    step();
    chk("T2 latency valid", ifa.tx_valid, 1'b1);
    chk("T2 latency active", ifa.frame_active, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("T2 hold data %0d", i), ifa.tx_data, 8'hA5);
      chk($sformatf("T2 hold valid %0d", i), ifa.tx_valid, 1'b1);
      step();
    end
    rdy_a = 1'b1;
    dm = dones_a;
    wait_done(1'b0, dm + 1, "T2");
    repeat (3) step();
    chk("T2 len", cap_a.size() - cm, LA);
    check_frame(1'b0, "T2", 2, cm, sb);
    // T3: FIFO underrun after the first sample
    cm = cap_a.size();
    sb = tail_a;
    dm = dones_a;
    push_a(16'h5A3C);
    repeat (15) step();
    chk("T3 waiting active", ifa.frame_active, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.tx_valid || ifa.data_read) bad++;
      step();
    end
    chk("T3 quiet in LOAD", bad, 0);
    push_a(16'hC3A5);
    wait_done(1'b0, dm + 1, "T3");
    repeat (3) step();
    chk("T3 len", cap_a.size() - cm, LA);
    check_frame(1'b0, "T3", 2, cm, sb);
    // T4: async reset during SEND_LO of sample 50
    for (int i = 0; i < 60; i++) push_b(16'(i * 257 + 11));
    t = 0;
    while (pops_b < 50 && t < 2000) begin step(); t++; end
    chk("T4 reached sample 50", pops_b, 50);
    step();
    chk("T4 mid frame", ifb.frame_active, 1'b1);
    #1 rst_b = 1'b0;
    #1;
    chk("T4 async tx_data", ifb.tx_data, 8'h00);
    chk("T4 async tx_valid", ifb.tx_valid, 1'b0);
    chk("T4 async data_read", ifb.data_read, 1'b0);
    chk("T4 async frame_active", ifb.frame_active, 1'b0);
    chk("T4 async frame_done", ifb.frame_done, 1'b0);
    tail_b = head_b;
    sb = tail_b;
    for (int i = 0; i < 125; i++) push_b(16'(i * 1021 + 7));
    step();
    rst_b = 1'b1;
    cm = cap_b.size();
    pm = pops_b;
    dm = dones_b;
    cyc_m = pop_cyc_b.size();
    // T5: full default-length frame back to back
    wait_done(1'b1, dm + 1, "T5");
    repeat (3) step();
    if (cap_b.size() > cm) chk("T4 first byte after reset", cap_b[cm], 8'hA5);
    else chk("T4 byte after reset", cap_b.size(), cm + 1);
    chk("T5 len", cap_b.size() - cm, LB);
    chk("T5 pops", pops_b - pm, 125);
    bad = 0;
    if (pop_cyc_b.size() >= cyc_m + 125)
      for (int i = cyc_m + 1; i < cyc_m + 125; i++)
        if (pop_cyc_b[i] - pop_cyc_b[i - 1] != 3) bad++;
    chk("T5 sample spacing", bad, 0);
    check_frame(1'b1, "T5", 125, cm, sb);
    // T6: random back-pressure over 10 frames
    cm = cap_a.size();
    pm = pops_a;
    dm = dones_a;
    sb = tail_a;
    rnd_a = 1'b1;
    for (int i = 0; i < 20; i++) push_a(16'($urandom));
    wait_done(1'b0, dm + 10, "T6");
    rnd_a = 1'b0;
    repeat (3) step();
    chk("T6 len", cap_a.size() - cm, 10 * LA);
    chk("T6 pops", pops_a - pm, 20);
    for (int f = 0; f < 10; f++) check_frame(1'b0, $sformatf("T6 f%0d", f), 2, cm + f * LA, sb + 2 * f);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
